// File: rtl/timeout_arbiter.sv
// Purpose : shares one countdown timer among N_REQ requesters, granted round-robin.
// Latency : grant/counter appear one edge after a request is seen while idle;
//           expired pulses on the edge that ends the V-cycle grant.
// Backpressure: none; a requester holds req until its expiry or drops req to abort.
//
// Ports:
//   clk_in   - free-running system clock
//   reset    - asynchronous, active-high
//   req      - per-requester request level
//   value    - packed per-requester timeout lengths, requester i at [i*W +: W]
//   grant    - one-hot owner of the timer
//   expired  - one-hot, one-cycle pulse when the owner's timeout elapses
//   running  - high while the timer counts
//   counter  - current countdown value
module timeout_arbiter #(
    parameter int N_REQ         = 4,
    parameter int COUNTER_WIDTH = 8
) (
    input  logic                             clk_in,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req,
    input  logic [N_REQ*COUNTER_WIDTH-1:0]   value,
    output logic [N_REQ-1:0]                 grant,
    output logic [N_REQ-1:0]                 expired,
    output logic                             running,
    output logic [COUNTER_WIDTH-1:0]         counter
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0]         ONE_HOT0 = N_REQ'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE  = COUNTER_WIDTH'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    state_t                   state_q,   state_d;
    logic [IDX_W-1:0]         last_q,    last_d;
    logic [N_REQ-1:0]         grant_q,   grant_d;
    logic [N_REQ-1:0]         expired_q, expired_d;
    logic                     running_q, running_d;
    logic [COUNTER_WIDTH-1:0] counter_q, counter_d;

    // Unpacked view of the per-requester timeout values.
    logic [COUNTER_WIDTH-1:0] val_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign val_arr[g] = value[g*COUNTER_WIDTH +: COUNTER_WIDTH];
    end

    // Round-robin pick: first eligible index after last_q, wrapping.
    // A requester that expired on the previous edge is masked so it cannot
    // win again before it has had a chance to drop req.
    logic [N_REQ-1:0]         eligible;
    logic                     pick_vld;
    logic [IDX_W-1:0]         pick_idx;
    logic [COUNTER_WIDTH-1:0] pick_val;
    logic [N_REQ-1:0]         pick_oh;
    int                       scan_int;
    logic [IDX_W-1:0]         scan_idx;

    always_comb begin
        eligible = req & ~expired_q;
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_val = '0;
        scan_int = 0;
        scan_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            scan_int = (int'(last_q) + k) % N_REQ;
            scan_idx = IDX_W'(scan_int);
            if (!pick_vld && eligible[scan_idx]) begin
                pick_vld = 1'b1;
                pick_idx = scan_idx;
                pick_val = val_arr[scan_idx];
            end
        end
        pick_oh = ONE_HOT0 << pick_idx;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        expired_d = '0;
        running_d = running_q;
        counter_d = counter_q;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    last_d = pick_idx;
                    if (pick_val != '0) begin
                        counter_d = pick_val;
                        grant_d   = pick_oh;
                        running_d = 1'b1;
                        state_d   = S_COUNT;
                    end else begin
                        // Zero-length timeout: expire straight from idle.
                        expired_d = pick_oh;
                    end
                end
            end
            S_COUNT: begin
                if ((req & grant_q) == '0) begin
                    // Owner dropped req: abort silently, beats expiry.
                    grant_d   = '0;
                    counter_d = '0;
                    running_d = 1'b0;
                    state_d   = S_IDLE;
                end else if (counter_q > CNT_ONE) begin
                    counter_d = counter_q - CNT_ONE;
                end else begin
                    counter_d = '0;
                    grant_d   = '0;
                    running_d = 1'b0;
                    expired_d = grant_q;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                grant_d   = '0;
                counter_d = '0;
                running_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(N_REQ - 1);
            grant_q   <= '0;
            expired_q <= '0;
            running_q <= 1'b0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            expired_q <= expired_d;
            running_q <= running_d;
            counter_q <= counter_d;
        end
    end

    assign grant   = grant_q;
    assign expired = expired_q;
    assign running = running_q;
    assign counter = counter_q;

endmodule

// File: tb/tb_timeout_arbiter.sv
// Purpose : self-checking bench for timeout_arbiter using a cycle scoreboard.
// Latency : expected outputs are queued when inputs are driven and popped after the edge.
// Backpressure: n/a; requesters are modelled as simple scripted agents.
module tb_timeout_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk_in = 1'b0;
    logic             reset  = 1'b1;
    logic [N-1:0]     req    = '0;
    logic [W-1:0]     vals [N];
    logic [N*W-1:0]   value_bus;
    logic [N-1:0]     grant;
    logic [N-1:0]     expired;
    logic             running;
    logic [W-1:0]     counter;

    always #5 clk_in = ~clk_in;

    always_comb begin
        value_bus = '0;
        for (int i = 0; i < N; i++) value_bus[i*W +: W] = vals[i];
    end

    timeout_arbiter #(.N_REQ(N), .COUNTER_WIDTH(W)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .req     (req),
        .value   (value_bus),
        .grant   (grant),
        .expired (expired),
        .running (running),
        .counter (counter)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp_v, $time);
    endtask

    // Reference model of the timer owner, driven by the same inputs.
    logic [N-1:0] m_grant, m_exp;
    logic         m_run;
    logic [W-1:0] m_cnt;
    int           m_last;

    task automatic model_reset();
        m_grant = '0; m_exp = '0; m_run = 1'b0; m_cnt = '0; m_last = N - 1;
    endtask

    task automatic model_step();
        logic [N-1:0] g, e;
        logic         r;
        logic [W-1:0] c;
        int           w;
        bit           found;
        g = m_grant; e = '0; r = m_run; c = m_cnt;
        if (!m_run) begin
            found = 1'b0;
            w = 0;
            for (int s = 1; s <= N; s++) begin
                if (!found && req[(m_last + s) % N] && !m_exp[(m_last + s) % N]) begin
                    found = 1'b1;
                    w = (m_last + s) % N;
                end
            end
            if (found) begin
                m_last = w;
                if (vals[w] != 0) begin
                    g = '0; g[w] = 1'b1; c = vals[w]; r = 1'b1;
                end else begin
                    e[w] = 1'b1;
                end
            end
        end else if ((req & m_grant) == 0) begin
            g = '0; c = '0; r = 1'b0;
        end else if (c == 1) begin
            e = m_grant; g = '0; c = '0; r = 1'b0;
        end else begin
            c = c - 1;
        end
        m_grant = g; m_exp = e; m_run = r; m_cnt = c;
    endtask

    typedef struct packed {
        logic [N-1:0] g;
        logic [N-1:0] e;
        logic         r;
        logic [W-1:0] c;
    } exp_t;

    exp_t sb_q[$];

    // Drive happens at the negedge; compare 1 ns after the rising edge.
    task automatic cycle();
        exp_t x;
        model_step();
        x.g = m_grant; x.e = m_exp; x.r = m_run; x.c = m_cnt;
        sb_q.push_back(x);
        @(posedge clk_in);
        #1;
        x = sb_q.pop_front();
        chk("grant",   32'(grant),   32'(x.g));
        chk("expired", 32'(expired), 32'(x.e));
        chk("running", 32'(running), 32'(x.r));
        chk("counter", 32'(counter), 32'(x.c));
        @(negedge clk_in);
    endtask

    // Assert reset immediately, check outputs cleared asynchronously,
    // release on the next negedge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_grant",   32'(grant),   0);
        chk("rst_expired", 32'(expired), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_counter", 32'(counter), 0);
        model_reset();
        sb_q.delete();
        @(negedge clk_in);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int gcnt, ecnt, idx;
        int rearm [N];
        int order [$];
        logic [N-1:0] prev_g;
        bit seen;
        int exp_order [5];

        for (int i = 0; i < N; i++) vals[i] = '0;
        model_reset();
        @(negedge clk_in);
        do_reset();

        // Single requester, value 3.
        vals[0] = 8'd3; req = 4'b0001;
        gcnt = 0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (grant[0]) gcnt++;
            if (m_exp[0]) req[0] = 1'b0;
        end
        chk("t1_grant_len", gcnt, 3);

        // All four requesting, value 2, drop on expiry, re-raise 2 cycles later.
        do_reset();
        for (int i = 0; i < N; i++) begin vals[i] = 8'd2; rearm[i] = 0; end
        req = 4'b1111;
        prev_g = '0;
        for (int k = 0; k < 16; k++) begin
            cycle();
            if (grant != 0 && prev_g == 0) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (grant[i]) idx = i;
                order.push_back(idx);
            end
            prev_g = grant;
            for (int i = 0; i < N; i++) begin
                if (rearm[i] > 0) begin
                    rearm[i]--;
                    if (rearm[i] == 0) req[i] = 1'b1;
                end
                if (m_exp[i]) begin req[i] = 1'b0; rearm[i] = 2; end
            end
        end
        exp_order = '{0, 1, 2, 3, 0};
        chk("t2_grant_count_ge5", 32'(order.size() >= 5), 1);
        for (int i = 0; i < 5 && i < order.size(); i++) chk("t2_rr_order", order[i], exp_order[i]);
        req = '0;
        repeat (3) cycle();

        // Zero-length timeout on requester 2.
        vals[2] = 8'd0; req = 4'b0100;
        gcnt = 0; ecnt = 0; seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            if (grant != 0) gcnt++;
            if (running) seen = 1'b1;
            if (expired == 4'b0100) ecnt++;
            if (m_exp[2]) req[2] = 1'b0;
        end
        chk("t3_no_grant", gcnt, 0);
        chk("t3_no_running", 32'(seen), 0);
        chk("t3_one_expiry", ecnt, 1);

        // Abort requester 1 at counter 6; pending requester 3 follows.
        vals[1] = 8'd10; req = 4'b0010;
        cycle();
        chk("t4_grant1", 32'(grant), 32'h2);
        vals[3] = 8'd4; req[3] = 1'b1;
        for (int k = 0; k < 20 && m_cnt != 6; k++) cycle();
        chk("t4_reach6", 32'(counter), 6);
        req[1] = 1'b0;
        cycle();
        chk("t4_abort_grant", 32'(grant), 0);
        chk("t4_abort_noexp", 32'(expired), 0);
        cycle();
        chk("t4_pending_grant", 32'(grant), 32'h8);
        for (int k = 0; k < 10 && req[3]; k++) begin
            cycle();
            if (m_exp[3]) req[3] = 1'b0;
        end
        repeat (2) cycle();

        // Async reset mid-count.
        vals[1] = 8'd8; req = 4'b0010;
        for (int k = 0; k < 20 && m_cnt != 5; k++) cycle();
        chk("t5_pre_cnt", 32'(counter), 5);
        chk("t5_pre_grant", 32'(grant), 32'h2);
        #2;
        for (int i = 0; i < N; i++) vals[i] = 8'd2;
        req = 4'b1111;
        do_reset();
        cycle();
        chk("t5_first_grant", 32'(grant), 32'h1);
        req = '0;
        repeat (3) cycle();

        // Maximum value 255.
        vals[0] = 8'd255; req = 4'b0001;
        gcnt = 0; seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            cycle();
            if (k == 0) chk("t6_start_cnt", 32'(counter), 255);
            if (grant[0]) gcnt++;
            if (m_exp[0]) begin seen = 1'b1; req[0] = 1'b0; end
        end
        chk("t6_expired_seen", 32'(seen), 1);
        chk("t6_grant_len", gcnt, 255);
        repeat (2) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/timeout_arbiter.md
Name: timeout_arbiter

Overview:
- Shares one countdown timer among N_REQ requesters, e.g. the UART command parser, the frame-buffer swap logic and the brightness fader.
- Each requester asks for a timeout of a given length.
- The block grants the timer round-robin, counts down, and returns a one-cycle expiry pulse to the owning requester.
- It sits between the control-path FSMs and the single shared countdown resource in the LED display controller.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- COUNTER_WIDTH, 8, width of the countdown value and counter.

Ports:
- clk_in  input  1  system clock; free-running.
- reset  input  1  asynchronous, active-high reset.
- req  input  N_REQ  per-requester request level; held high until expired or abort.
- value  input  N_REQ*COUNTER_WIDTH  per-requester count, packed; requester i uses bits [i*W +: W].
- grant  output  N_REQ  one-hot; the requester that currently owns the timer.
- expired  output  N_REQ  one-hot, one-cycle pulse; the owner's timeout has elapsed.
- running  output  1  high while the timer counts (state COUNT).
- counter  output  COUNTER_WIDTH  current countdown value.

Behaviour:
- Reset (asynchronous, active-high):
  - grant=0, expired=0, running=0, counter=0, state=IDLE.
  - Round-robin pointer last=N_REQ-1, so requester 0 has first priority.
- All other state updates on the rising edge of clk_in.
- States are IDLE and COUNT; all outputs are registered.
- IDLE:
  - Eligible set = req & ~expired. The mask stops a requester that has just expired from re-winning before it drops req.
  - If the eligible set is empty: stay in IDLE, expired <= 0.
  - Otherwise pick the first eligible index scanning last+1, last+2, ... mod N_REQ; call it i. Then last <= i.
  - If value[i] != 0: counter <= value[i], grant <= onehot(i), running <= 1, state <= COUNT.
  - If value[i] == 0: expired <= onehot(i), grant stays 0, counter stays 0, state stays IDLE. This is a zero-length timeout.
- COUNT:
  - Abort: req of the granted requester low. Next edge: grant <= 0, counter <= 0, running <= 0, no expired pulse, state <= IDLE. Abort takes precedence over expiry on the same edge.
  - counter > 1: counter <= counter - 1.
  - counter == 1: counter <= 0, grant <= 0, running <= 0, expired <= grant (one cycle), state <= IDLE.
  - Other requests are ignored; no preemption.
- expired is cleared on every edge where it is not explicitly set.
- Timing for value V >= 1:
  - grant is high for exactly V cycles.
  - expired rises on the same edge grant falls.
  - The next arbitration occurs one edge later, so there is a minimum one-cycle gap between grants.
- Counter arithmetic is unsigned, width COUNTER_WIDTH, with no wrap. Decrement never occurs from 0.
- Max V = 2^COUNTER_WIDTH - 1 (255 at default).
- value is sampled only at the arbitration edge; later changes are ignored.
- Reset mid-COUNT aborts immediately with no expired pulse.
- Simultaneous requests are resolved purely by round-robin order.

Test Plan:
- Reset, then req=0001, value[0]=3 → grant=0001 for 3 cycles, counter 3,2,1, then expired=0001 for one cycle; running mirrors grant.
- req=1111 held, all values=2; each requester drops req on its expired cycle and re-raises it 2 cycles later → grant order 0,1,2,3,0 with a one-cycle gap between grants.
- req[2]=1 with value[2]=0 → expired=0100 one cycle after arbitration, grant never asserted, running stays 0.
- Grant requester 1 with value=10, drop req[1] when counter=6 → grant, running and counter are 0 on the next edge, no expired pulse; a pending req[3] is granted on the following edge.
- Assert reset asynchronously mid-count (counter=5, grant=0010) → all outputs 0 immediately, before the next clock edge. After release, with req=1111, the first grant goes to requester 0.
- value=255 with req held → counter starts at 255, expired pulses after exactly 255 grant cycles, counter never wraps.
